// File: rtl/hwag_tooth_period.sv
// Tooth-period timer and missing-tooth synchroniser for the HWAG angle generator.
// Optional build macro HWAG_TOOTH_CHECK_EN enables tooth-count checking at the gap.
module hwag_tooth_period #(
  parameter int WIDTH   = 24,
  parameter int TEETH   = 60,
  parameter int MISSING = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             edge_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic [7:0]       tooth_num,
  output logic             gap,
  output logic             synced,
  output logic             overflow,
  output logic             sync_err
);

  // state    | meaning
  // S_IDLE   | block disabled, everything held cleared
  // S_FIRST  | waiting for the edge that starts a measurement
  // S_SECOND | next edge yields the first period (no gap test)
  // S_HUNT   | measuring, searching for the gap
  // S_SYNC   | locked to the wheel, tooth_num tracks position
  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_SECOND,
    S_HUNT,
    S_SYNC
  } state_t;

  localparam logic [7:0] LAST_TOOTH = 8'(TEETH - 1);
  localparam logic [7:0] GAP_TOOTH  = 8'(TEETH - MISSING - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] prev_period, prev_nx;
  logic [WIDTH-1:0] period_new, period_nx;
  logic             period_valid_nx, gap_nx, synced_nx, overflow_nx, sync_err_nx;
  logic [7:0]       tooth_nx, tooth_inc;
  logic             cnt_max, gap_hit, tooth_mismatch;

  assign cnt_max    = &cnt;
  assign period_new = cnt_max ? cnt : cnt + WIDTH'(1);
  // Compare at WIDTH+1 bits so doubling prev_period cannot wrap.
  assign gap_hit    = {1'b0, period_new} >= {prev_period, 1'b0};
  assign tooth_inc  = (tooth_num == LAST_TOOTH) ? tooth_num : tooth_num + 8'd1;

`ifdef HWAG_TOOTH_CHECK_EN
  assign tooth_mismatch = gap_hit != (tooth_num == GAP_TOOTH);
`else
  assign tooth_mismatch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!ena) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_FIRST;
        S_FIRST: if (edge_in) state_nx = S_SECOND;
        S_SECOND: begin
          if (cnt_max)      state_nx = edge_in ? S_SECOND : S_FIRST;
          else if (edge_in) state_nx = S_HUNT;
        end
        S_HUNT: begin
          if (cnt_max)                 state_nx = edge_in ? S_SECOND : S_FIRST;
          else if (edge_in && gap_hit) state_nx = S_SYNC;
        end
        S_SYNC: begin
          if (cnt_max)                        state_nx = edge_in ? S_SECOND : S_FIRST;
          else if (edge_in && tooth_mismatch) state_nx = S_HUNT;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nx          = cnt;
    prev_nx         = prev_period;
    period_nx       = period;
    period_valid_nx = 1'b0;
    gap_nx          = 1'b0;
    tooth_nx        = tooth_num;
    synced_nx       = synced;
    overflow_nx     = overflow;
    sync_err_nx     = 1'b0;
    if (!ena || state == S_IDLE) begin
      cnt_nx      = '0;
      prev_nx     = '0;
      period_nx   = '0;
      tooth_nx    = '0;
      synced_nx   = 1'b0;
      overflow_nx = 1'b0;
    end else begin
      if (edge_in)       cnt_nx = '0;
      else if (!cnt_max) cnt_nx = cnt + WIDTH'(1);

      if (cnt_max) begin
        // An edge landing on saturation still restarts the measurement.
        overflow_nx = 1'b1;
        synced_nx   = 1'b0;
        tooth_nx    = '0;
        if (edge_in) period_nx = '1;
      end else if (edge_in && state != S_FIRST) begin
        period_nx       = period_new;
        period_valid_nx = 1'b1;
        prev_nx         = period_new;
        if (state == S_HUNT && gap_hit) begin
          gap_nx    = 1'b1;
          tooth_nx  = '0;
          synced_nx = 1'b1;
        end else if (state == S_SYNC) begin
          if (tooth_mismatch) begin
            sync_err_nx = 1'b1;
            synced_nx   = 1'b0;
            tooth_nx    = '0;
          end else if (gap_hit) begin
            gap_nx   = 1'b1;
            tooth_nx = '0;
          end else begin
            tooth_nx = tooth_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      prev_period  <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      gap          <= 1'b0;
      tooth_num    <= '0;
      synced       <= 1'b0;
      overflow     <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      prev_period  <= prev_nx;
      period       <= period_nx;
      period_valid <= period_valid_nx;
      gap          <= gap_nx;
      tooth_num    <= tooth_nx;
      synced       <= synced_nx;
      overflow     <= overflow_nx;
      sync_err     <= sync_err_nx;
    end
  end

endmodule

// File: tb/tb_hwag_tooth_period.sv
// Directed bench for hwag_tooth_period: 60-2 wheel, overflow (8-bit instance),
// reset, acceleration / tooth-check and back-to-back edges.
module tb_hwag_tooth_period;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0, edge_in = 1'b0;
  logic        ena8 = 1'b0, edge8 = 1'b0;

  logic [23:0] period;
  logic        period_valid, gap, synced, overflow, sync_err;
  logic [7:0]  tooth_num;
  logic [7:0]  period8;
  logic        period_valid8, gap8, synced8, overflow8, sync_err8;
  logic [7:0]  tooth_num8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic        valid;
    logic [23:0] per;
    logic        gp;
    logic [7:0]  tooth;
    logic        syn;
  } vec_t;

  vec_t vq[$];

  hwag_tooth_period #(.WIDTH(24), .TEETH(60), .MISSING(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in),
    .period(period), .period_valid(period_valid), .tooth_num(tooth_num),
    .gap(gap), .synced(synced), .overflow(overflow), .sync_err(sync_err)
  );

  hwag_tooth_period #(.WIDTH(8), .TEETH(60), .MISSING(2)) dut8 (
    .clk(clk), .rst(rst), .ena(ena8), .edge_in(edge8),
    .period(period8), .period_valid(period_valid8), .tooth_num(tooth_num8),
    .gap(gap8), .synced(synced8), .overflow(overflow8), .sync_err(sync_err8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge lands n cycles after the previous one; returns just after that edge's clock.
  task automatic pulse(input int n, input int which);
    if (which == 0) edge_in = 1'b0; else edge8 = 1'b0;
    repeat (n - 1) tick();
    if (which == 0) edge_in = 1'b1; else edge8 = 1'b1;
    tick();
    if (which == 0) edge_in = 1'b0; else edge8 = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic v, input logic [23:0] p, input logic g,
                     input logic [7:0] t, input logic s);
    vec_t r;
    r.n = n; r.valid = v; r.per = p; r.gp = g; r.tooth = t; r.syn = s;
    vq.push_back(r);
  endtask

  initial begin
    add(5, 1'b0, 24'd0, 1'b0, 8'd0, 1'b0);
    repeat (3) add(100, 1'b1, 24'd100, 1'b0, 8'd0, 1'b0);
    add(300, 1'b1, 24'd300, 1'b1, 8'd0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int t = 1; t <= 57; t++) add(100, 1'b1, 24'd100, 1'b0, 8'(t), 1'b1);
      add(300, 1'b1, 24'd300, 1'b1, 8'd0, 1'b1);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {period, period_valid, tooth_num, gap, synced, overflow, sync_err}, 64'd0);
    rst = 1'b1;
    ena = 1'b1;
    tick();

    // 60-2 wheel, two revolutions
    foreach (vq[i]) begin
      pulse(vq[i].n, 0);
      chk($sformatf("wheel_%0d", i),
          {period_valid, period, gap, tooth_num, synced, sync_err},
          {vq[i].valid, vq[i].per, vq[i].gp, vq[i].tooth, vq[i].syn, 1'b0});
    end
    tick();
    chk("strobes_idle", {period_valid, gap}, 2'b00);

`ifdef HWAG_TOOTH_CHECK_EN
    // Extra tooth: non-gap edge at tooth 57 loses sync
    for (int t = 1; t <= 57; t++) pulse(100, 0);
    chk("pre_extra_tooth", {tooth_num, synced}, {8'd57, 1'b1});
    pulse(100, 0);
    chk("extra_tooth_err", {sync_err, synced, tooth_num, gap, period_valid},
        {1'b1, 1'b0, 8'd0, 1'b0, 1'b1});
    tick();
    chk("sync_err_one_cycle", sync_err, 1'b0);
    pulse(300, 0);
    chk("resync_after_err", {gap, synced, tooth_num, sync_err}, {1'b1, 1'b1, 8'd0, 1'b0});
    repeat (3) pulse(100, 0);
    chk("pre_early_gap", tooth_num, 8'd3);
    pulse(300, 0);
    chk("early_gap_err", {sync_err, synced, gap, tooth_num}, {1'b1, 1'b0, 1'b0, 8'd0});
    pulse(100, 0);
    pulse(300, 0);
    chk("resync_2", {gap, synced, tooth_num}, {1'b1, 1'b1, 8'd0});
`else
    // Accelerating wheel: 150 < 2*80, so no gap; tooth_num saturates at 59
    for (int t = 1; t <= 56; t++) pulse(100, 0);
    chk("accel_tooth56", tooth_num, 8'd56);
    pulse(90, 0);
    chk("accel_90", {period, tooth_num}, {24'd90, 8'd57});
    pulse(80, 0);
    chk("accel_80", {period, tooth_num}, {24'd80, 8'd58});
    pulse(150, 0);
    chk("accel_150_nogap", {period, gap, tooth_num, synced}, {24'd150, 1'b0, 8'd59, 1'b1});
    pulse(80, 0);
    chk("accel_tooth_sat", {tooth_num, synced, gap}, {8'd59, 1'b1, 1'b0});
`endif

    // Asynchronous reset mid-revolution
    pulse(100, 0);
    chk("synced_before_reset", synced, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {period, period_valid, tooth_num, gap, synced, overflow, sync_err}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    pulse(50, 0);
    chk("post_reset_first_edge", {period_valid, period}, {1'b0, 24'd0});
    pulse(100, 0);
    chk("post_reset_second_edge", {period_valid, period}, {1'b1, 24'd100});
    pulse(300, 0);
    chk("post_reset_gap", {gap, synced, tooth_num}, {1'b1, 1'b1, 8'd0});

    // Back-to-back edges while synced
    for (int i = 1; i <= 5; i++) begin
      pulse(1, 0);
      chk($sformatf("b2b_%0d", i), {period_valid, period, gap, tooth_num, synced},
          {1'b1, 24'd1, 1'b0, 8'(i), 1'b1});
    end
    tick();
    chk("b2b_end", {period_valid, gap}, 2'b00);

    // 8-bit timer overflow
    ena8 = 1'b1;
    tick();
    pulse(10, 1);
    pulse(20, 1);
    chk("w8_period", {period_valid8, period8}, {1'b1, 8'd20});
    pulse(50, 1);
    chk("w8_sync", {gap8, synced8, overflow8}, 3'b110);
    repeat (300) tick();
    chk("w8_overflow", {overflow8, synced8, period8}, {1'b1, 1'b0, 8'd50});
    pulse(1, 1);
    chk("w8_edge_at_sat", {period8, period_valid8, overflow8}, {8'hff, 1'b0, 1'b1});
    pulse(30, 1);
    chk("w8_restart", {period_valid8, period8, overflow8}, {1'b1, 8'd30, 1'b1});
    pulse(255, 1);
    chk("w8_max_period", {period_valid8, period8, gap8, synced8, overflow8},
        {1'b1, 8'd255, 1'b1, 1'b1, 1'b1});
    ena8 = 1'b0;
    tick();
    chk("w8_ena_clear", {overflow8, synced8, period8, tooth_num8}, {1'b0, 1'b0, 8'd0, 8'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
